exe_sched: RTL and testbench

EXE_SCHED -- requirements
Module: exe_sched

---
 rtl/exe_pkg.sv | 29 ++
 rtl/exe_sched_if.sv | 42 ++++
 rtl/cond_eval.sv | 39 +++
 rtl/exe_sched.sv | 136 +++++++++++++
 tb/tb_exe_sched.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_pkg.sv
// Shared types and constants for the execute-stage scheduler: opcode type,
// RFLAGS bit positions, scheduler state encoding and IMUL latency default.
package exe_pkg;

  typedef logic [9:0] opcode_t;

  localparam opcode_t OP_IMUL = 10'h0F7;
  localparam opcode_t OP_JMP  = 10'h0EB;

  localparam int RF_CF = 0;
  localparam int RF_PF = 2;
  localparam int RF_ZF = 6;
  localparam int RF_SF = 7;
  localparam int RF_OF = 11;

  localparam logic [63:0] RFLAGS_RESET = 64'h2;
  localparam int unsigned MUL_LAT_DEFAULT = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // Both Jcc encodings share a 6-bit prefix; the low nibble is the condition.
  function automatic logic is_jcc(opcode_t op);
    return (op[9:4] == 6'b00_0111) || (op[9:4] == 6'b01_1000);
  endfunction

endpackage

// File: rtl/exe_sched_if.sv
// Decode-side, ALU-side and control signals of the execute scheduler.
interface exe_sched_if;
  import exe_pkg::*;

  // Decode handshake: an instruction transfers on a cycle where dec_valid and
  // dec_ready are both high; dec_* fields must be stable while dec_valid waits.
  logic        dec_valid;
  logic        dec_ready;
  opcode_t     dec_opcode;
  logic [63:0] dec_oprd1;
  logic [63:0] dec_oprd2;
  logic [63:0] dec_oprd3;
  logic [63:0] dec_next_rip;

  logic        alu_enable;
  opcode_t     alu_opcode;
  logic [63:0] alu_oprd1;
  logic [63:0] alu_oprd2;
  logic [63:0] alu_oprd3;
  logic [63:0] alu_next_rip;
  logic [63:0] alu_rflags;

  logic        mem_blocked;
  logic        branch;
  logic [63:0] branch_rip;
  logic [63:0] rflags_q;

  modport master (
    output dec_valid, dec_opcode, dec_oprd1, dec_oprd2, dec_oprd3, dec_next_rip,
    output alu_rflags, mem_blocked,
    input  dec_ready, alu_enable, alu_opcode, alu_oprd1, alu_oprd2, alu_oprd3,
    input  alu_next_rip, branch, branch_rip, rflags_q
  );

  modport slave (
    input  dec_valid, dec_opcode, dec_oprd1, dec_oprd2, dec_oprd3, dec_next_rip,
    input  alu_rflags, mem_blocked,
    output dec_ready, alu_enable, alu_opcode, alu_oprd1, alu_oprd2, alu_oprd3,
    output alu_next_rip, branch, branch_rip, rflags_q
  );

endinterface

// File: rtl/cond_eval.sv
// x86 condition-code evaluator: odd condition codes are the negation of the
// even code below them, so only eight base predicates are decoded.
module cond_eval
  import exe_pkg::*;
(
  input  logic [3:0]  cond,
  input  logic [63:0] flags,
  output logic        taken
);

  logic cf, pf, zf, sf, of;
  logic base;
  logic unused_flags;

  assign cf = flags[RF_CF];
  assign pf = flags[RF_PF];
  assign zf = flags[RF_ZF];
  assign sf = flags[RF_SF];
  assign of = flags[RF_OF];
  assign unused_flags = ^{flags[63:12], flags[10:8], flags[5:3], flags[1]};

  always_comb begin
    base = 1'b0;
    unique case (cond[3:1])
      3'd0: base = of;
      3'd1: base = cf;
      3'd2: base = zf;
      3'd3: base = cf | zf;
      3'd4: base = sf;
      3'd5: base = pf;
      3'd6: base = sf ^ of;
      3'd7: base = zf | (sf ^ of);
      default: base = 1'b0;
    endcase
  end

  assign taken = base ^ cond[0];

endmodule

// File: rtl/exe_sched.sv
// Execute-stage scheduler: issues decoded ops to the ALU (holding IMUL for
// MUL_LAT cycles), resolves branches locally and keeps architectural RFLAGS.
module exe_sched
  import exe_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  exe_sched_if.slave bus,
  output state_t     dbg_state
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        en_q, en_d;
  opcode_t     op_q, op_d;
  logic [63:0] oprd1_q, oprd1_d;
  logic [63:0] oprd2_q, oprd2_d;
  logic [63:0] oprd3_q, oprd3_d;
  logic [63:0] nrip_q, nrip_d;
  logic [63:0] flags_q, flags_d;
  logic        br_q, br_d;
  logic [63:0] brip_q, brip_d;

  logic        ready;
  logic        accept;
  logic        flag_load;
  logic [63:0] flags_eval;
  logic        cond_taken;
  logic        is_branch;

  assign ready  = (state_q == IDLE) && !bus.mem_blocked && !br_q;
  assign accept = bus.dec_valid && ready;

  // The last unblocked cycle of an issue commits alu_rflags; a Jcc accepted in
  // that same cycle is evaluated against the value being committed.
  assign flag_load  = en_q && !bus.mem_blocked && ((state_q == IDLE) || (cnt_q == 4'd0));
  assign flags_eval = flag_load ? bus.alu_rflags : flags_q;
  assign is_branch  = is_jcc(bus.dec_opcode) || (bus.dec_opcode == OP_JMP);

  cond_eval u_cond_eval (
    .cond  (bus.dec_opcode[3:0]),
    .flags (flags_eval),
    .taken (cond_taken)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    op_d    = op_q;
    oprd1_d = oprd1_q;
    oprd2_d = oprd2_q;
    oprd3_d = oprd3_q;
    nrip_d  = nrip_q;
    flags_d = flags_q;
    br_d    = 1'b0;
    brip_d  = '0;
    if (!bus.mem_blocked) begin
      if (flag_load) flags_d = bus.alu_rflags;
      unique case (state_q)
        IDLE: begin
          en_d = 1'b0;
          if (accept) begin
            if (is_branch) begin
              br_d   = (bus.dec_opcode == OP_JMP) || cond_taken;
              brip_d = br_d ? (bus.dec_next_rip + bus.dec_oprd1) : 64'h0;
            end else begin
              en_d    = 1'b1;
              op_d    = bus.dec_opcode;
              oprd1_d = bus.dec_oprd1;
              oprd2_d = bus.dec_oprd2;
              oprd3_d = bus.dec_oprd3;
              nrip_d  = bus.dec_next_rip;
              if (bus.dec_opcode == OP_IMUL) begin
                state_d = MUL;
                cnt_d   = 4'(MUL_LAT - 1);
              end
            end
          end
        end
        MUL: begin
          if (cnt_q == 4'd0) begin
            state_d = IDLE;
            en_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      op_q    <= '0;
      oprd1_q <= '0;
      oprd2_q <= '0;
      oprd3_q <= '0;
      nrip_q  <= '0;
      flags_q <= RFLAGS_RESET;
      br_q    <= 1'b0;
      brip_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      op_q    <= op_d;
      oprd1_q <= oprd1_d;
      oprd2_q <= oprd2_d;
      oprd3_q <= oprd3_d;
      nrip_q  <= nrip_d;
      flags_q <= flags_d;
      br_q    <= br_d;
      brip_q  <= brip_d;
    end
  end

  assign bus.dec_ready    = ready;
  assign bus.alu_enable   = en_q;
  assign bus.alu_opcode   = op_q;
  assign bus.alu_oprd1    = oprd1_q;
  assign bus.alu_oprd2    = oprd2_q;
  assign bus.alu_oprd3    = oprd3_q;
  assign bus.alu_next_rip = nrip_q;
  assign bus.branch       = br_q;
  assign bus.branch_rip   = brip_q;
  assign bus.rflags_q     = flags_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_exe_sched.sv
// Directed bench for exe_sched: a transaction-level model (remaining issue
// cycles, flags, branch pulse) is compared against the DUT every cycle.
module tb_exe_sched;
  import exe_pkg::*;

  localparam int MUL_LAT = 4;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;

  exe_sched_if ifc ();

  exe_sched #(.MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (ifc),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit cond_ok(input logic [3:0] c, input logic [63:0] f);
    bit cf, pf, zf, sf, of;
    cf = f[0]; pf = f[2]; zf = f[6]; sf = f[7]; of = f[11];
    case (c)
      4'h0: return of;
      4'h1: return !of;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return zf;
      4'h5: return !zf;
      4'h6: return cf || zf;
      4'h7: return !(cf || zf);
      4'h8: return sf;
      4'h9: return !sf;
      4'hA: return pf;
      4'hB: return !pf;
      4'hC: return sf != of;
      4'hD: return sf == of;
      4'hE: return zf || (sf != of);
      default: return !(zf || (sf != of));
    endcase
  endfunction

  function automatic bit is_br_op(input logic [9:0] op);
    return (op >= 10'h070 && op <= 10'h07F) || (op >= 10'h180 && op <= 10'h18F) || (op == 10'h0EB);
  endfunction

  bit          m_valid = 0;
  int          m_rem = 0;      // ALU cycles still to be spent on the current issue
  bit          m_mul = 0;
  logic [9:0]  m_op = '0;
  logic [63:0] m_o1 = '0, m_o2 = '0, m_o3 = '0, m_nrip = '0;
  logic [63:0] m_flags = 64'h2;
  bit          m_br = 0;
  logic [63:0] m_brip = '0;
  bit          m_acc, m_nbr;
  logic [63:0] m_fl, m_nbrip;

  function automatic bit m_ready();
    return !(m_rem > 0 && m_mul) && !ifc.mem_blocked && !m_br;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1; m_rem = 0; m_mul = 0; m_op = '0;
      m_o1 = '0; m_o2 = '0; m_o3 = '0; m_nrip = '0;
      m_flags = 64'h2; m_br = 0; m_brip = '0;
    end else if (m_valid) begin
      m_acc = ifc.dec_valid && m_ready();
      m_fl = m_flags; m_nbr = 0; m_nbrip = '0;
      if (!ifc.mem_blocked) begin
        if (m_rem == 1) m_fl = ifc.alu_rflags;
        if (m_rem > 0) m_rem = m_rem - 1;
        if (m_acc) begin
          if (is_br_op(ifc.dec_opcode)) begin
            m_nbr = (ifc.dec_opcode == 10'h0EB) || cond_ok(ifc.dec_opcode[3:0], m_fl);
            m_nbrip = m_nbr ? ifc.dec_next_rip + ifc.dec_oprd1 : 64'h0;
          end else begin
            m_op = ifc.dec_opcode; m_o1 = ifc.dec_oprd1; m_o2 = ifc.dec_oprd2;
            m_o3 = ifc.dec_oprd3; m_nrip = ifc.dec_next_rip;
            m_mul = (ifc.dec_opcode == 10'h0F7);
            m_rem = m_mul ? MUL_LAT : 1;
          end
        end
      end
      m_flags = m_fl; m_br = m_nbr; m_brip = m_nbrip;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("alu_enable", 64'(ifc.alu_enable), 64'(m_rem > 0));
      chk("dec_ready", 64'(ifc.dec_ready), 64'(m_ready()));
      chk("branch", 64'(ifc.branch), 64'(m_br));
      chk("branch_rip", ifc.branch_rip, m_brip);
      chk("rflags_q", ifc.rflags_q, m_flags);
      chk("dbg_state", 64'(dbg_state), (m_rem > 0 && m_mul) ? 64'(MUL) : 64'(IDLE));
      if (m_rem > 0) begin
        chk("alu_opcode", 64'(ifc.alu_opcode), 64'(m_op));
        chk("alu_oprd1", ifc.alu_oprd1, m_o1);
        chk("alu_oprd2", ifc.alu_oprd2, m_o2);
        chk("alu_oprd3", ifc.alu_oprd3, m_o3);
        chk("alu_next_rip", ifc.alu_next_rip, m_nrip);
      end
    end
  end

  bit cnt_on = 0;
  int bg_en = 0, bg_rdy_blk = 0;
  always @(negedge clk) begin
    if (cnt_on) begin
      bg_en += int'(ifc.alu_enable);
      if (ifc.mem_blocked && ifc.dec_ready) bg_rdy_blk++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction and returns just after the edge that accepted it.
  task automatic issue(input logic [9:0] op, input logic [63:0] o1, input logic [63:0] o2,
                       input logic [63:0] o3, input logic [63:0] nrip);
    bit ok;
    ok = 0;
    ifc.dec_valid = 1'b1; ifc.dec_opcode = op; ifc.dec_oprd1 = o1;
    ifc.dec_oprd2 = o2; ifc.dec_oprd3 = o3; ifc.dec_next_rip = nrip;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = ifc.dec_ready;
      step();
    end
    ifc.dec_valid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout: opcode %h not accepted, expected acceptance within 40 cycles", op);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_cnt, r_lo;
    logic [9:0] jop;
    logic [63:0] flag_set[4];
    flag_set[0] = 64'h881; flag_set[1] = 64'h0; flag_set[2] = 64'h44; flag_set[3] = 64'h80;

    ifc.dec_valid = 0; ifc.dec_opcode = '0; ifc.dec_oprd1 = '0; ifc.dec_oprd2 = '0;
    ifc.dec_oprd3 = '0; ifc.dec_next_rip = '0; ifc.alu_rflags = '0; ifc.mem_blocked = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_alu_enable", 64'(ifc.alu_enable), 0);
    chk("rst_rflags", ifc.rflags_q, 64'h2);
    chk("rst_branch", 64'(ifc.branch), 0);
    chk("rst_branch_rip", ifc.branch_rip, 0);
    chk("rst_alu_opcode", 64'(ifc.alu_opcode), 0);
    chk("rst_alu_oprd1", ifc.alu_oprd1, 0);
    chk("rst_dec_ready", 64'(ifc.dec_ready), 1);
    step();

    // single-cycle ADD commits its flags
    ifc.alu_rflags = 64'h46;
    issue(10'h001, 64'h11, 64'h22, 64'h33, 64'h100);
    @(negedge clk); chk("add_en_c1", 64'(ifc.alu_enable), 1);
    step();
    @(negedge clk); chk("add_en_c2", 64'(ifc.alu_enable), 0); chk("add_rflags", ifc.rflags_q, 64'h46);
    step();

    // JE taken with ZF=1
    issue(10'h074, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 64'h1000);
    @(negedge clk);
    chk("je_branch", 64'(ifc.branch), 1);
    chk("je_branch_rip", ifc.branch_rip, 64'h0FF0);
    chk("je_alu_enable", 64'(ifc.alu_enable), 0);
    chk("je_dec_ready", 64'(ifc.dec_ready), 0);
    step();
    @(negedge clk); chk("je_pulse_end", 64'(ifc.branch), 0);
    step();

    // JE not taken with ZF=0
    ifc.alu_rflags = 64'h0;
    issue(10'h001, 1, 2, 3, 64'h200);
    step();
    issue(10'h074, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 64'h1000);
    @(negedge clk); chk("jne_branch", 64'(ifc.branch), 0); chk("jne_branch_rip", ifc.branch_rip, 0);
    step();

    // IMUL holds the ALU for MUL_LAT cycles
    ifc.alu_rflags = 64'h881;
    issue(10'h0F7, 64'h7, 64'h9, 64'h3, 64'h300);
    e_cnt = 0; r_lo = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e_cnt += int'(ifc.alu_enable);
      r_lo += int'(!ifc.dec_ready);
      step();
    end
    chk("imul_en_cycles", 64'(e_cnt), 4);
    chk("imul_ready_low", 64'(r_lo), 4);
    @(negedge clk); chk("imul_rflags", ifc.rflags_q, 64'h881);
    step();

    // condition sweep over both Jcc encodings and several flag values
    for (int f = 0; f < 4; f++) begin
      ifc.alu_rflags = flag_set[f];
      issue(10'h029, 64'(f), 64'h5, 64'h6, 64'h400);
      step();
      for (int c = 0; c < 16; c++) begin
        jop = (c % 2 == 1) ? (10'h070 | 10'(c)) : (10'h180 | 10'(c));
        issue(jop, 64'(c) - 64'd8, 0, 0, 64'h5000 + 64'(c));
        step();
      end
    end

    // back-to-back single-cycle ops, second one unrecognised
    ifc.alu_rflags = 64'h84;
    issue(10'h001, 64'hA, 64'hB, 64'hC, 64'h600);
    ifc.alu_rflags = 64'h801;
    issue(10'h3FF, 64'hD, 64'hE, 64'hF, 64'h610);
    step();
    @(negedge clk); chk("b2b_rflags", ifc.rflags_q, 64'h801);
    step();

    // single-cycle op stretched by a two-cycle stall
    ifc.alu_rflags = 64'h40;
    issue(10'h3FF, 64'h1, 64'h2, 64'h3, 64'h700);
    ifc.mem_blocked = 1;
    step(); step();
    ifc.mem_blocked = 0;
    @(negedge clk); chk("stall1_en_held", 64'(ifc.alu_enable), 1);
    step();
    @(negedge clk); chk("stall1_en_done", 64'(ifc.alu_enable), 0); chk("stall1_rflags", ifc.rflags_q, 64'h40);
    step();

    // IMUL with a three-cycle stall starting in its second cycle
    ifc.alu_rflags = 64'h4;
    issue(10'h0F7, 64'h21, 64'h22, 64'h23, 64'h800);
    bg_en = 0; bg_rdy_blk = 0; cnt_on = 1;
    step();
    ifc.mem_blocked = 1;
    step(); step(); step();
    ifc.mem_blocked = 0;
    repeat (6) step();
    cnt_on = 0;
    chk("stall_imul_en_cycles", 64'(bg_en), 7);
    chk("stall_ready_while_blocked", 64'(bg_rdy_blk), 0);
    @(negedge clk); chk("stall_imul_rflags", ifc.rflags_q, 64'h4);
    step();

    // reset in the second IMUL cycle aborts without a flag update
    ifc.alu_rflags = 64'hFFF;
    issue(10'h0F7, 64'h31, 64'h32, 64'h33, 64'h900);
    step();
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    chk("rst_mul_en", 64'(ifc.alu_enable), 0);
    chk("rst_mul_rflags", ifc.rflags_q, 64'h2);
    chk("rst_mul_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_mul_ready", 64'(ifc.dec_ready), 1);
    step();

    // JMP target wraps modulo 2^64
    issue(10'h0EB, 64'h4, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    chk("jmp_branch", 64'(ifc.branch), 1);
    chk("jmp_branch_rip", ifc.branch_rip, 64'h2);
    chk("jmp_dec_ready", 64'(ifc.dec_ready), 0);
    chk("jmp_alu_enable", 64'(ifc.alu_enable), 0);
    step();
    @(negedge clk); chk("jmp_pulse_end", 64'(ifc.branch), 0);
    step();

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
